// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared defaults, types and FSM states for mem_responder
package mem_responder_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    localparam int CNT_W  = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/mem_array_1rw.sv
// rtl/mem_array_1rw.sv - single-port synchronous array, registered read, write-first selectable
module mem_array_1rw #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 5,
    parameter int DEPTH       = 32,
    parameter bit WRITE_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents and read register are deliberately unreset; the owner clears the array.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= (WRITE_FIRST && we_i) ? wdata_i : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - 32x16 responder with clear sweep, priority host port and counters
module mem_responder #(
    parameter int DATA_W = mem_responder_pkg::DATA_W,
    parameter int ADDR_W = mem_responder_pkg::ADDR_W,
    parameter int DEPTH  = mem_responder_pkg::DEPTH,
    parameter int CNT_W  = mem_responder_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic              mem_read_enable,
    input  logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic              host_sel,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              init_done,
    output logic              conflict,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);
    import mem_responder_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              init_done_q, conflict_q, conflict_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic              ctrl_rd_q, ctrl_rd_d, host_rd_q, host_rd_d;
    logic [DATA_W-1:0] mem_hold_q, host_hold_q;

    logic              arr_we, arr_re;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;

    mem_array_1rw #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WRITE_FIRST (1'b1)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        conflict_d = conflict_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        ctrl_rd_d  = 1'b0;
        host_rd_d  = 1'b0;
        arr_we     = 1'b0;
        arr_re     = 1'b0;
        arr_addr   = mem_address;
        arr_wdata  = mem_data_in;
        unique case (state_q)
            CLEAR: begin
                arr_we     = 1'b1;
                arr_addr   = clr_addr_q;
                arr_wdata  = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (host_sel) begin
                    arr_we    = host_we;
                    arr_re    = !host_we;
                    arr_addr  = host_addr;
                    arr_wdata = host_wdata;
                    host_rd_d = !host_we;
                    if (mem_read_enable || mem_write_enable) begin
                        conflict_d = 1'b1;
                    end
                end else begin
                    arr_we    = mem_write_enable;
                    arr_re    = mem_read_enable;
                    ctrl_rd_d = mem_read_enable;
                    if (mem_write_enable && (wr_cnt_q != '1)) begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                    if (mem_read_enable && (rd_cnt_q != '1)) begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            init_done_q <= 1'b0;
            conflict_q  <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            ctrl_rd_q   <= 1'b0;
            host_rd_q   <= 1'b0;
            mem_hold_q  <= '0;
            host_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_done_q <= (state_d == READY);
            conflict_q  <= conflict_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            ctrl_rd_q   <= ctrl_rd_d;
            host_rd_q   <= host_rd_d;
            if (ctrl_rd_q) mem_hold_q  <= arr_rdata;
            if (host_rd_q) host_hold_q <= arr_rdata;
        end
    end

    // The array's read register is shared; each output shows it only for the cycle after its own read.
    assign mem_data_out = ctrl_rd_q ? arr_rdata : mem_hold_q;
    assign host_rdata   = host_rd_q ? arr_rdata : host_hold_q;
    assign init_done    = init_done_q;
    assign conflict     = conflict_q;
    assign rd_count     = rd_cnt_q;
    assign wr_count     = wr_cnt_q;
endmodule
